// File: rtl/ipml_sync_fifo_v2_0.sv
// Single-clock FIFO with selectable standard-read or first-word-fall-through output.
// Latency: standard read data one cycle after rd_en; FWFT head valid two edges after a write into empty.
// Backpressure: wr_full / rd_empty gate acceptance; rejected requests only raise overflow/underflow pulses.
module ipml_sync_fifo_v2_0 #(
  parameter int c_DEPTH_WIDTH      = 10,
  parameter int c_DATA_WIDTH       = 32,
  parameter int c_FWFT             = 0,
  parameter int c_ALMOST_FULL_NUM  = 1020,
  parameter int c_ALMOST_EMPTY_NUM = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [c_DATA_WIDTH-1:0]  wr_data,
  input  logic                     wr_en,
  output logic                     wr_full,
  output logic                     almost_full,
  output logic [c_DATA_WIDTH-1:0]  rd_data,
  input  logic                     rd_en,
  output logic                     rd_empty,
  output logic                     rd_valid,
  output logic                     almost_empty,
  output logic [c_DEPTH_WIDTH:0]   water_level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = 1 << c_DEPTH_WIDTH;
  localparam logic [c_DEPTH_WIDTH:0] FULL_LEVEL = {1'b1, {c_DEPTH_WIDTH{1'b0}}};
  localparam logic [31:0] AF_NUM = 32'(c_ALMOST_FULL_NUM);
  localparam logic [31:0] AE_NUM = 32'(c_ALMOST_EMPTY_NUM);

  logic [c_DATA_WIDTH-1:0]  mem [DEPTH];
  logic [c_DATA_WIDTH-1:0]  mem_q;
  logic [c_DEPTH_WIDTH-1:0] wr_ptr;
  logic [c_DEPTH_WIDTH-1:0] rd_ptr;
  logic [c_DEPTH_WIDTH:0]   level_next;
  logic [31:0]              level_next_ext;
  logic                     wr_acc;
  logic                     rd_acc;    // word leaves the FIFO (pop)
  logic                     rd_issue;  // array read performed this edge

  // Requests during reset are ignored, so acceptance is masked by rst.
  assign wr_acc = wr_en && !wr_full && !rst;

  // Total occupancy moves only when exactly one of push/pop happens.
  always_comb begin
    level_next = water_level;
    if (wr_acc && !rd_acc) begin
      level_next = water_level + 1'b1;
    end else if (!wr_acc && rd_acc) begin
      level_next = water_level - 1'b1;
    end
  end

  assign level_next_ext = 32'(level_next);

  // Occupancy, full and threshold flags all track the same next-level value.
  always_ff @(posedge clk) begin
    if (rst) begin
      water_level  <= '0;
      wr_full      <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      water_level  <= level_next;
      wr_full      <= (level_next == FULL_LEVEL);
      almost_full  <= (level_next_ext >= AF_NUM);
      almost_empty <= (level_next_ext <= AE_NUM);
    end
  end

  // Error pulses are one cycle per offending request and never sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && wr_full;
      underflow <= rd_en && rd_empty;
    end
  end

  // Binary pointers wrap naturally at 2^W.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Registered read port; read and write never target the same live slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (rd_issue) begin
      mem_q <= mem[rd_ptr];
    end
  end

  if (c_FWFT == 0) begin : g_std
    logic empty_q;
    logic valid_q;

    assign rd_acc   = rd_en && !empty_q && !rst;
    assign rd_issue = rd_acc;

    // Empty follows the occupancy so a word written at edge k is poppable at k+1.
    always_ff @(posedge clk) begin
      if (rst) begin
        empty_q <= 1'b1;
        valid_q <= 1'b0;
      end else begin
        empty_q <= (level_next == '0);
        valid_q <= rd_acc;
      end
    end

    assign rd_empty = empty_q;
    assign rd_valid = valid_q;
    assign rd_data  = mem_q;
  end else begin : g_fwft
    // Two-stage output: mem_q (pend) feeds the visible head register.
    logic [c_DEPTH_WIDTH:0]  arr_cnt;   // words in the array not yet read out
    logic                    pend;
    logic                    head_vld;
    logic [c_DATA_WIDTH-1:0] head_q;
    logic                    head_load;

    assign rd_acc    = rd_en && head_vld && !rst;
    assign head_load = pend && (!head_vld || rd_acc);
    // Only read the array when the fetched word has somewhere to go next edge.
    assign rd_issue  = (arr_cnt != '0) && (!pend || head_load) && !rst;

    // Array occupancy, fetch-pending flag and head register advance together.
    always_ff @(posedge clk) begin
      if (rst) begin
        arr_cnt  <= '0;
        pend     <= 1'b0;
        head_vld <= 1'b0;
        head_q   <= '0;
      end else begin
        arr_cnt <= arr_cnt + {{c_DEPTH_WIDTH{1'b0}}, wr_acc}
                           - {{c_DEPTH_WIDTH{1'b0}}, rd_issue};
        if (rd_issue) begin
          pend <= 1'b1;
        end else if (head_load) begin
          pend <= 1'b0;
        end
        if (head_load) begin
          head_q   <= mem_q;
          head_vld <= 1'b1;
        end else if (rd_acc) begin
          head_vld <= 1'b0;
        end
      end
    end

    assign rd_empty = !head_vld;
    assign rd_valid = head_vld;
    assign rd_data  = head_q;
  end

endmodule

// File: tb/tb_ipml_sync_fifo_v2_0.sv
// Directed bench: standard-mode vector table plus FWFT hand sequences.
module tb_ipml_sync_fifo_v2_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // standard-mode instance
  logic       s_rst, s_wr_en, s_rd_en;
  logic [7:0] s_wr_data, s_rd_data;
  logic       s_full, s_af, s_empty, s_vld, s_ae, s_ovf, s_udf;
  logic [4:0] s_wl;

  // FWFT instance
  logic       f_rst, f_wr_en, f_rd_en;
  logic [7:0] f_wr_data, f_rd_data;
  logic       f_full, f_af, f_empty, f_vld, f_ae, f_ovf, f_udf;
  logic [4:0] f_wl;

  ipml_sync_fifo_v2_0 #(
    .c_DEPTH_WIDTH(4), .c_DATA_WIDTH(8), .c_FWFT(0),
    .c_ALMOST_FULL_NUM(14), .c_ALMOST_EMPTY_NUM(2)
  ) u_std (
    .clk(clk), .rst(s_rst), .wr_data(s_wr_data), .wr_en(s_wr_en),
    .wr_full(s_full), .almost_full(s_af), .rd_data(s_rd_data), .rd_en(s_rd_en),
    .rd_empty(s_empty), .rd_valid(s_vld), .almost_empty(s_ae),
    .water_level(s_wl), .overflow(s_ovf), .underflow(s_udf)
  );

  ipml_sync_fifo_v2_0 #(
    .c_DEPTH_WIDTH(4), .c_DATA_WIDTH(8), .c_FWFT(1),
    .c_ALMOST_FULL_NUM(14), .c_ALMOST_EMPTY_NUM(2)
  ) u_fwft (
    .clk(clk), .rst(f_rst), .wr_data(f_wr_data), .wr_en(f_wr_en),
    .wr_full(f_full), .almost_full(f_af), .rd_data(f_rd_data), .rd_en(f_rd_en),
    .rd_empty(f_empty), .rd_valid(f_vld), .almost_empty(f_ae),
    .water_level(f_wl), .overflow(f_ovf), .underflow(f_udf)
  );

  typedef struct {
    logic       rst, wr_en, rd_en;
    logic [7:0] wr_data;
    logic [4:0] wl;
    logic       full, empty, af, ae, vld;
    logic [7:0] rdat;
    logic       ovf, udf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(logic rst, logic we, logic re, logic [7:0] wd,
                               int wl, logic full, logic empty, logic af, logic ae,
                               logic vld, logic [7:0] rdat, logic ovf, logic udf);
    vec_t v;
    v.rst = rst; v.wr_en = we; v.rd_en = re; v.wr_data = wd;
    v.wl = 5'(wl); v.full = full; v.empty = empty; v.af = af; v.ae = ae;
    v.vld = vld; v.rdat = rdat; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  initial begin
    s_rst = 1'b1; s_wr_en = 1'b0; s_rd_en = 1'b0; s_wr_data = '0;
    f_rst = 1'b1; f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;

    // ---------------- standard-mode table (AF=14, AE=2) ----------------
    //                  rst we re data  wl full emp af ae vld rdat  ovf udf
    vecs.push_back(mkv(1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00, 0, 0));
    for (int i = 1; i <= 16; i++)
      vecs.push_back(mkv(0, 1, 0, 8'(i), i, i == 16, 0, i >= 14, i <= 2, 0, 8'h00, 0, 0));
    // full with simultaneous write/read: read wins, write rejected
    vecs.push_back(mkv(0, 1, 1, 8'h77, 15, 0, 0, 1, 0, 1, 8'h01, 1, 0));
    for (int k = 1; k <= 15; k++)
      vecs.push_back(mkv(0, 0, 1, 8'h00, 15 - k, 0, k == 15, (15 - k) >= 14, (15 - k) <= 2,
                         1, 8'(1 + k), 0, 0));
    vecs.push_back(mkv(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h10, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 0, 8'h10, 0, 1));
    for (int i = 0; i < 9; i++)
      vecs.push_back(mkv(0, 1, 0, 8'(8'h20 + i), i + 1, 0, 0, 0, (i + 1) <= 2, 0, 8'h10, 0, 0));
    // reset with 9 stored words and a write request
    vecs.push_back(mkv(1, 1, 0, 8'h99, 0, 0, 1, 0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mkv(0, 1, 0, 8'h55, 1, 0, 0, 0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 8'h55, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h55, 0, 0));

    foreach (vecs[i]) begin
      s_rst = vecs[i].rst; s_wr_en = vecs[i].wr_en;
      s_rd_en = vecs[i].rd_en; s_wr_data = vecs[i].wr_data;
      tick();
      chk($sformatf("std v%0d water_level", i), 32'(s_wl), 32'(vecs[i].wl));
      chk($sformatf("std v%0d wr_full", i), 32'(s_full), 32'(vecs[i].full));
      chk($sformatf("std v%0d rd_empty", i), 32'(s_empty), 32'(vecs[i].empty));
      chk($sformatf("std v%0d almost_full", i), 32'(s_af), 32'(vecs[i].af));
      chk($sformatf("std v%0d almost_empty", i), 32'(s_ae), 32'(vecs[i].ae));
      chk($sformatf("std v%0d rd_valid", i), 32'(s_vld), 32'(vecs[i].vld));
      chk($sformatf("std v%0d rd_data", i), 32'(s_rd_data), 32'(vecs[i].rdat));
      chk($sformatf("std v%0d overflow", i), 32'(s_ovf), 32'(vecs[i].ovf));
      chk($sformatf("std v%0d underflow", i), 32'(s_udf), 32'(vecs[i].udf));
    end
    s_wr_en = 1'b0; s_rd_en = 1'b0;

    // ---------------- FWFT sequences ----------------
    f_rst = 1'b1;
    tick();
    chk("fw reset empty", 32'(f_empty), 32'd1);
    chk("fw reset valid", 32'(f_vld), 32'd0);
    chk("fw reset level", 32'(f_wl), 32'd0);
    chk("fw reset rd_data", 32'(f_rd_data), 32'd0);
    f_rst = 1'b0;

    // single word fall-through: visible after edge k+2
    f_wr_en = 1'b1; f_wr_data = 8'hA5;
    tick();
    f_wr_en = 1'b0;
    chk("fw k empty", 32'(f_empty), 32'd1);
    chk("fw k level", 32'(f_wl), 32'd1);
    tick();
    chk("fw k+1 empty", 32'(f_empty), 32'd1);
    tick();
    chk("fw k+2 empty", 32'(f_empty), 32'd0);
    chk("fw k+2 valid", 32'(f_vld), 32'd1);
    chk("fw k+2 rd_data", 32'(f_rd_data), 32'hA5);
    chk("fw k+2 level", 32'(f_wl), 32'd1);
    f_rd_en = 1'b1;
    tick();
    chk("fw pop empty", 32'(f_empty), 32'd1);
    chk("fw pop level", 32'(f_wl), 32'd0);
    chk("fw pop underflow", 32'(f_udf), 32'd0);
    tick();
    f_rd_en = 1'b0;
    chk("fw underflow", 32'(f_udf), 32'd1);
    chk("fw underflow level", 32'(f_wl), 32'd0);
    tick();
    chk("fw underflow clear", 32'(f_udf), 32'd0);

    // fill to capacity, then one rejected write
    for (int i = 0; i < 16; i++) begin
      f_wr_en = 1'b1; f_wr_data = 8'(8'hC0 + i);
      tick();
      chk($sformatf("fw fill%0d level", i), 32'(f_wl), 32'(i + 1));
      chk($sformatf("fw fill%0d full", i), 32'(f_full), 32'(i == 15));
    end
    f_wr_data = 8'hEE;
    tick();
    f_wr_en = 1'b0;
    chk("fw overflow", 32'(f_ovf), 32'd1);
    chk("fw overflow level", 32'(f_wl), 32'd16);
    chk("fw almost_full", 32'(f_af), 32'd1);
    f_rd_en = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("fw drain%0d empty", j), 32'(f_empty), 32'd0);
      chk($sformatf("fw drain%0d data", j), 32'(f_rd_data), 32'(8'hC0 + j));
      tick();
    end
    f_rd_en = 1'b0;
    chk("fw drain end empty", 32'(f_empty), 32'd1);
    chk("fw drain end level", 32'(f_wl), 32'd0);
    chk("fw drain end ovf", 32'(f_ovf), 32'd0);

    // streaming: 100 cycles of simultaneous write/read across pointer wraps
    begin
      int exp_d;
      int pops;
      exp_d = 0; pops = 0;
      for (int c = 1; c <= 100; c++) begin
        f_wr_en = 1'b1; f_rd_en = 1'b1; f_wr_data = 8'(c - 1);
        if (!f_empty) begin
          chk($sformatf("fw stream pop%0d", pops), 32'(f_rd_data), 32'(8'(exp_d)));
          exp_d++; pops++;
        end
        tick();
        if (c >= 3) begin
          chk($sformatf("fw stream c%0d no bubble", c), 32'(f_empty), 32'd0);
          chk($sformatf("fw stream c%0d level", c), 32'(f_wl), 32'd3);
        end
      end
      f_wr_en = 1'b0; f_rd_en = 1'b0;
      chk("fw stream pop count", 32'(pops), 32'd97);
    end

    // reset mid-operation with a pending write
    f_rst = 1'b1; f_wr_en = 1'b1; f_wr_data = 8'h99;
    tick();
    f_rst = 1'b0;
    chk("fw rst level", 32'(f_wl), 32'd0);
    chk("fw rst empty", 32'(f_empty), 32'd1);
    chk("fw rst almost_empty", 32'(f_ae), 32'd1);
    chk("fw rst ovf", 32'(f_ovf), 32'd0);
    chk("fw rst udf", 32'(f_udf), 32'd0);
    f_wr_data = 8'h3C;
    tick();
    f_wr_en = 1'b0;
    tick();
    chk("fw post-rst k+1 empty", 32'(f_empty), 32'd1);
    tick();
    chk("fw post-rst empty", 32'(f_empty), 32'd0);
    chk("fw post-rst data", 32'(f_rd_data), 32'h3C);
    chk("fw post-rst level", 32'(f_wl), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ipml_sync_fifo_v2_0.md
Name: ipml_sync_fifo_v2_0

Overview:
Single-clock, parameterised FIFO. It is the synchronous-only successor to the vendor dual-clock FIFO wrapper.
- Adds a selectable first-word-fall-through (FWFT) mode, a single water-level count, threshold flags, and overflow/underflow error pulses.
- Storage is an inferred simple-dual-port array with registered read.
- Used in datapaths where producer and consumer share one clock (address stores, line buffers).

Parameters:
c_DEPTH_WIDTH, 10, log2 of depth; legal 4..20; capacity = 2^c_DEPTH_WIDTH words in both modes
c_DATA_WIDTH, 32, word width; legal 1..1152
c_FWFT, 0, 0 = standard read (data one cycle after rd_en); 1 = first-word-fall-through
c_ALMOST_FULL_NUM, 1020, almost_full asserted when water_level >= this value
c_ALMOST_EMPTY_NUM, 4, almost_empty asserted when water_level <= this value

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  synchronous reset, active-high
wr_data  input  c_DATA_WIDTH  write word
wr_en  input  1  write request
wr_full  output  1  FIFO holds 2^c_DEPTH_WIDTH words
almost_full  output  1  threshold flag
rd_data  output  c_DATA_WIDTH  read word
rd_en  input  1  read request (pop in FWFT)
rd_empty  output  1  no word readable
rd_valid  output  1  rd_data carries a freshly popped word (standard mode); equals !rd_empty (FWFT mode)
almost_empty  output  1  threshold flag
water_level  output  c_DEPTH_WIDTH+1  words held, including the FWFT output register
overflow  output  1  one-cycle pulse: wr_en while wr_full
underflow  output  1  one-cycle pulse: rd_en while rd_empty

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high, applied on clk rising edge with rst=1.
- Reset values:
  - rd_empty=1, wr_full=0, almost_empty=1, almost_full=0, water_level=0.
  - rd_valid=0, rd_data=0, overflow=0, underflow=0.
  - Pointers cleared. Array contents are not cleared.
  - Reset mid-operation discards all contents; requests sampled in the reset cycle are ignored; no pulses are generated.
- Accept rules:
  - Write accepted iff wr_en && !wr_full.
  - Read accepted iff rd_en && !rd_empty.
  - Rejected requests have no effect except the error pulse.
  - Full with simultaneous wr_en and rd_en: read accepted, write rejected, overflow pulses.
  - Empty with simultaneous wr_en and rd_en: write accepted, read rejected, underflow pulses.
- Pointers: c_DEPTH_WIDTH-bit binary write and read pointers, wrapping naturally from 2^W-1 to 0.
- water_level:
  - Registered; +1 on accepted write only, -1 on accepted pop only, unchanged on both or neither.
  - Never exceeds 2^W and never underflows.
  - wr_full = (water_level == 2^W), registered, updated on the same edge as water_level.
- Thresholds: almost_full = (next water_level >= c_ALMOST_FULL_NUM); almost_empty = (next water_level <= c_ALMOST_EMPTY_NUM). Both registered and coincident with water_level.
- Standard mode (c_FWFT=0):
  - rd_empty = (water_level == 0).
  - Accepted read at edge k: rd_data is updated at edge k+1 and rd_valid=1 for exactly that cycle.
  - rd_data holds its value otherwise.
  - Write at edge k into an empty FIFO: rd_empty=0 after edge k; a read accepted at edge k+1 returns that word.
- FWFT mode (c_FWFT=1):
  - An output register holds the head word; rd_empty = !head_valid; rd_valid = head_valid.
  - Prefetch: when the head is invalid or being popped and the array is non-empty, issue an array read; the head loads one edge later.
  - Write at edge k into an empty FIFO: rd_empty falls after edge k+2, and rd_data shows the word in the same cycle.
  - Back-to-back pops with the array non-empty present a new head every cycle with no bubbles.
  - water_level counts array words plus the head; capacity stays 2^W.
- Data ordering: strictly in write order; no word is lost or duplicated across pointer wrap.
- Error pulses: overflow and underflow are registered and high for one cycle per offending request cycle. They are not sticky.

Test Plan:
- Standard mode, W=4, 8-bit: write 0x01..0x10 (16 words) -> wr_full=1 after the 16th edge, water_level=16, almost_full per threshold. Read 16 -> data 0x01..0x10 in order, rd_valid one cycle after each rd_en, rd_empty=1 at end.
- Full FIFO, wr_en=1 and rd_en=1 for 1 cycle -> overflow=1 for one cycle, water_level=15, wr_full=0, the rejected word is never read.
- FWFT mode: write 0xA5 to an empty FIFO at edge k -> rd_empty falls after edge k+2 with rd_data=0xA5 without rd_en; pop -> rd_empty=1 next cycle.
- FWFT streaming: continuous wr_en and rd_en for 100 cycles across 6 pointer wraps -> output stream equals the input stream, no bubbles after fill, water_level stable.
- rd_en on an empty FIFO -> underflow=1 for one cycle, rd_data unchanged, water_level=0.
- Assert rst with 9 words stored and wr_en=1 -> next cycle water_level=0, rd_empty=1, almost_empty=1, no pulses; a subsequent write and read returns only the new data.
